// File: rtl/addsub_pkg.sv
// Shared types for the multi-word add/subtract sequencer.
// Holds the FSM state encoding and the ctrl opcode values.
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_add.sv
// N-bit adder built from generate/propagate terms.
// One instance serves every limb of the sequential add/subtract.
module cla_add #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] g;
    logic [N-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // The carry recurrence is kept inside one process so the chain stays
    // local; synthesis is free to restructure it into a prefix network.
    always_comb begin
        logic cc;
        sum = '0;
        cc  = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = p[i] ^ cc;
            cc     = g[i] | (p[i] & cc);
        end
        cout = cc;
    end
endmodule

// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract: one W-bit limb per cycle through a single adder,
// with valid/ready handshakes on both the request and result sides.
module mw_addsub_seq
    import addsub_pkg::*;
#(
    parameter int N = 256,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         ctrl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout
);
    localparam int WS = (W < 1) ? 1 : W;
    localparam int K  = N / WS;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if ((W < 1) || (N % WS != 0)) begin : g_bad_params
        $error("mw_addsub_seq: W must be >= 1 and divide N");
    end

    state_t        state, state_nx;
    logic [N-1:0]  a_q, b_q, res_q;
    logic          ctrl_q, carry_q, cout_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  limb_sum;
    logic          limb_cin, limb_cout;
    int            base;

    assign base      = W * int'(cnt);
    assign limb_cin  = (cnt == '0) ? ctrl_q : carry_q;

    // b_q already holds b ^ {N{ctrl}}, so the adder sees subtract as a + ~b + 1
    cla_add #(.N(W)) u_limb_add (
        .a    (a_q[base +: W]),
        .b    (b_q[base +: W]),
        .cin  (limb_cin),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)             state_nx = RUN;
            RUN:  if (cnt == LAST)          state_nx = DONE;
            DONE: if (out_ready)            state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= OP_ADD;
            carry_q <= 1'b0;
            cnt     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= a;
                    b_q    <= b ^ {N{ctrl}};
                    ctrl_q <= ctrl;
                    cnt    <= '0;
                end
                RUN: begin
                    res_q[base +: W] <= limb_sum;
                    carry_q          <= limb_cout;
                    if (cnt == LAST) cout_q <= limb_cout;
                    else             cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_mw_addsub_seq.sv
// Randomized self-checking bench for mw_addsub_seq against a plain-arithmetic
// model of (a + b) / (a - b) mod 2^N with carry / no-borrow flag.
module tb_mw_addsub_seq;
    localparam int N = 256;
    localparam int W = 64;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         ctrl;
    logic [N-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;

    int checks = 0;
    int errors = 0;

    mw_addsub_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rnd_word();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: plain modular arithmetic, flag = carry for add, a >= b for sub
    function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic op, output logic [N-1:0] r, output logic c);
        logic [N:0] s;
        if (op) begin
            r = x - y;
            c = (x >= y);
        end else begin
            s = {1'b0, x} + {1'b0, y};
            r = s[N-1:0];
            c = s[N];
        end
    endfunction

    // Issue one request, wait for out_valid (bounded), return what was seen,
    // leaving the result un-accepted so callers can inspect or stall.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic op,
                         input bit scramble, output int lat);
        @(negedge clk);
        a = x; b = y; ctrl = op; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a = rnd_word(); b = rnd_word(); ctrl = 1'($urandom); in_valid = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; ctrl = 1'b0;
        a = rnd_word(); b = rnd_word();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (result !== '0 || cout !== 1'b0) begin
            errors++; $display("FAIL reset_result result=%h cout=%b want 0/0", result, cout);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_valid_ignored in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic run_case(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic op, input bit scramble);
        logic [N-1:0] er;
        logic ec;
        int lat;
        model(x, y, op, er, ec);
        issue(x, y, op, scramble, lat);
        checks++;
        if (lat != K + 1) begin
            errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, K + 1);
        end
        checks++;
        if (result !== er || cout !== ec) begin
            errors++; $display("FAIL %s result=%h cout=%b want %h/%b", name, result, cout, er, ec);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_accept out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_corners();
        logic [N-1:0] ones, v, m64;
        ones = '1;
        v    = {4{64'h1234_5678_9abc_def0}};
        m64  = {{(N-64){1'b0}}, {64{1'b1}}};
        run_case("add_wrap", ones, 1, 1'b0, 1'b0);
        run_case("sub_borrow", 0, 1, 1'b1, 1'b0);
        run_case("sub_equal", v, v, 1'b1, 1'b0);
        run_case("add_limb_carry_scrambled", m64, 1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_case("random", rnd_word(), rnd_word(), 1'($urandom), i[0]);
    endtask

    task automatic test_stall();
        logic [N-1:0] x, y, er, held;
        logic ec, hc;
        int lat;
        x = rnd_word(); y = rnd_word();
        model(x, y, 1'b0, er, ec);
        issue(x, y, 1'b0, 1'b0, lat);
        held = result; hc = cout;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin a = rnd_word(); b = rnd_word(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (result !== er || cout !== ec || result !== held || cout !== hc
                || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d result=%h cout=%b in_ready=%b out_valid=%b want %h/%b/0/1",
                         i, result, cout, in_ready, out_valid, er, ec);
            end
        end
        in_valid = 1'b0;
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_accept out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        run_case("after_stall", rnd_word(), rnd_word(), 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        a = rnd_word(); b = rnd_word(); ctrl = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);        // RUN, limb 0
        in_valid = 1'b0;
        @(negedge clk);        // limb 1
        @(negedge clk);        // limb 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid in_ready=%b out_valid=%b result=%h cout=%b want 1/0/0/0",
                     in_ready, out_valid, result, cout);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_discard out_valid_seen=%b want 0", seen);
        end
        run_case("after_reset", rnd_word(), rnd_word(), 1'b0, 1'b0);
    endtask

    task automatic test_idle_hold();
        logic [N-1:0] held;
        logic hc;
        held = result; hc = cout;
        for (int i = 0; i < 5; i++) begin
            a = rnd_word(); b = rnd_word(); ctrl = 1'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (result !== held || cout !== hc) begin
            errors++; $display("FAIL idle_hold result=%h cout=%b want %h/%b", result, cout, held, hc);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; ctrl = 1'b0; a = '0; b = '0; rst_n = 1'b0;
        test_reset();
        test_corners();
        test_random();
        test_stall();
        test_reset_mid();
        test_idle_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
